// File: rtl/sseg_scan_driver.sv
// Multiplexed 4-digit active-low seven-segment driver with guard interval, per-digit blank and blink.
// Define SSEG_LZB_EN to enable leading-zero blanking of digits 3..1.
module sseg_scan_driver #(
    parameter int REFRESH_DIV = 100000,
    parameter int GUARD_CYC   = 4,
    parameter int BLINK_DIV   = 50000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [15:0] digits,
    input  logic [3:0]  dp_in,
    input  logic [3:0]  blank_in,
    input  logic [3:0]  blink_in,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [3:0]  an,
    output logic        scan_tick
);

    localparam int CW = $clog2(REFRESH_DIV);
    localparam int BW = $clog2(BLINK_DIV);
    localparam logic [CW-1:0] CNT_LAST   = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] GUARD_END  = CW'(GUARD_CYC);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    idx_q, idx_d;
    logic [BW-1:0] blinkCnt_q, blinkCnt_d;
    logic          blinkPhase_q, blinkPhase_d;
    logic [15:0]   digits_q;
    logic [3:0]    dpShadow_q, blank_q, blink_q;
    logic [6:0]    seg_q, seg_d;
    logic [3:0]    an_q, an_d;
    logic          dpOut_q, dpOut_d;
    logic          tick_q, tick_d;
    logic          cntWrap, blinkWrap, dark;
    logic [3:0]    nibble;
    logic [3:0]    lzbDark;

    function automatic logic [6:0] decode(input logic [3:0] nib);
        case (nib)
            4'h0: return 7'h40;
            4'h1: return 7'h79;
            4'h2: return 7'h24;
            4'h3: return 7'h30;
            4'h4: return 7'h19;
            4'h5: return 7'h12;
            4'h6: return 7'h02;
            4'h7: return 7'h78;
            4'h8: return 7'h00;
            4'h9: return 7'h10;
            4'hA: return 7'h08;
            4'hB: return 7'h03;
            4'hC: return 7'h46;
            4'hD: return 7'h21;
            4'hE: return 7'h06;
            default: return 7'h0E;
        endcase
    endfunction

`ifdef SSEG_LZB_EN
    // A digit is a leading zero only if it and every digit to its left are zero.
    logic z3, z2, z1;
    assign z3 = (digits_q[15:12] == 4'h0);
    assign z2 = (digits_q[11:8] == 4'h0);
    assign z1 = (digits_q[7:4] == 4'h0);
    assign lzbDark = {z3, z3 & z2, z3 & z2 & z1, 1'b0};
`else
    assign lzbDark = 4'b0000;
`endif

    always_comb begin
        cntWrap      = (cnt_q == CNT_LAST);
        cnt_d        = cntWrap ? '0 : cnt_q + 1'b1;
        idx_d        = cntWrap ? idx_q + 2'd1 : idx_q;
        tick_d       = cntWrap;
        blinkWrap    = (blinkCnt_q == BLINK_LAST);
        blinkCnt_d   = blinkWrap ? '0 : blinkCnt_q + 1'b1;
        blinkPhase_d = blinkPhase_q ^ blinkWrap;
        nibble       = digits_q[{idx_q, 2'b00} +: 4];
        dark         = (cnt_q < GUARD_END) | blank_q[idx_q]
                     | (blink_q[idx_q] & blinkPhase_q) | lzbDark[idx_q];
        an_d         = dark ? 4'hF : ~(4'b0001 << idx_q);
        seg_d        = dark ? 7'h7F : decode(nibble);
        dpOut_d      = dark ? 1'b1 : ~dpShadow_q[idx_q];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q        <= '0;
            idx_q        <= '0;
            blinkCnt_q   <= '0;
            blinkPhase_q <= 1'b0;
            digits_q     <= '0;
            dpShadow_q   <= '0;
            blank_q      <= '0;
            blink_q      <= '0;
            an_q         <= 4'hF;
            seg_q        <= 7'h7F;
            dpOut_q      <= 1'b1;
            tick_q       <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            blinkCnt_q   <= blinkCnt_d;
            blinkPhase_q <= blinkPhase_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
            dpOut_q      <= dpOut_d;
            tick_q       <= tick_d;
            // Shadow capture never disturbs the scan position.
            if (load) begin
                digits_q   <= digits;
                dpShadow_q <= dp_in;
                blank_q    <= blank_in;
                blink_q    <= blink_in;
            end
        end
    end

    assign seg       = seg_q;
    assign dp        = dpOut_q;
    assign an        = an_q;
    assign scan_tick = tick_q;

endmodule

// File: tb/tb_sseg_scan_driver.sv
// Self-checking bench for sseg_scan_driver with REFRESH_DIV=8, GUARD_CYC=2, BLINK_DIV=64.
// Expected values for leading-zero cases follow SSEG_LZB_EN when it is defined.
module tb_sseg_scan_driver;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        load;
    logic [15:0] digits;
    logic [3:0]  dp_in, blank_in, blink_in;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic        scan_tick;

    int tests = 0;
    int failures = 0;
    int edges = 0;

    typedef struct {
        logic [15:0] digits;
        logic [3:0]  dpIn;
        logic [3:0]  blankIn;
        logic [3:0]  blinkIn;
        int          slot;
        int          phase;
        logic [3:0]  expAn;
        logic [6:0]  expSeg;
        logic        expDp;
    } vec_t;

    vec_t vecs[$];

    sseg_scan_driver #(
        .REFRESH_DIV(8),
        .GUARD_CYC(2),
        .BLINK_DIV(64)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .load(load),
        .digits(digits),
        .dp_in(dp_in),
        .blank_in(blank_in),
        .blink_in(blink_in),
        .seg(seg),
        .dp(dp),
        .an(an),
        .scan_tick(scan_tick)
    );

    always #5 clk = ~clk;

    // Independent count of released edges gives the expected scan position.
    always @(posedge clk) begin
        if (!rst_n) edges <= 0;
        else        edges <= edges + 1;
    end

    function automatic int curCnt();
        return (edges - 1) % 8;
    endfunction

    function automatic int curIdx();
        return ((edges - 1) / 8) % 4;
    endfunction

    function automatic int curPhase();
        return ((edges - 1) / 64) % 2;
    endfunction

    function automatic vec_t mkVec(input logic [15:0] d, input logic [3:0] p, input logic [3:0] bl,
                                   input logic [3:0] bk, input int slot, input int phase,
                                   input logic [3:0] ea, input logic [6:0] es, input logic ed);
        vec_t v;
        v.digits = d; v.dpIn = p; v.blankIn = bl; v.blinkIn = bk;
        v.slot = slot; v.phase = phase;
        v.expAn = ea; v.expSeg = es; v.expDp = ed;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [3:0] expAn,
                               input logic [6:0] expSeg, input logic expDp);
        tests++;
        if (an !== expAn || seg !== expSeg || dp !== expDp) begin
            failures++;
            $display("[TB] FAIL %s: got an=%b seg=%h dp=%b, expected an=%b seg=%h dp=%b",
                     name, an, seg, dp, expAn, expSeg, expDp);
        end
    endtask

    task automatic checkTick(input string name, input logic expTick);
        tests++;
        if (scan_tick !== expTick) begin
            failures++;
            $display("[TB] FAIL %s: got scan_tick=%b, expected %b", name, scan_tick, expTick);
        end
    endtask

    // Loads content; returns at the first negedge whose outputs reflect it.
    task automatic applyStimulus(input logic [15:0] d, input logic [3:0] p,
                                 input logic [3:0] bl, input logic [3:0] bk);
        @(negedge clk);
        digits = d; dp_in = p; blank_in = bl; blink_in = bk; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        @(negedge clk);
    endtask

    task automatic waitPos(input string name, input int slot, input int cnt, input int phase);
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            if (curIdx() == slot && curCnt() == cnt && (phase < 0 || curPhase() == phase)) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            tests++;
            failures++;
            $display("[TB] FAIL %s: scan position slot=%0d cnt=%0d never reached, got edges=%0d",
                     name, slot, cnt, edges);
        end
    endtask

    initial begin
        logic [3:0] walkAn[4];
        logic [6:0] walkSeg[4];
        logic       walkDp[4];
        int c, ix;

        walkAn  = '{4'hE, 4'hD, 4'hB, 4'h7};
        walkSeg = '{7'h0E, 7'h08, 7'h24, 7'h79};
        walkDp  = '{1'b0, 1'b1, 1'b1, 1'b1};

        vecs.push_back(mkVec(16'h12AF, 4'b0001, 4'b0000, 4'b0000, 0, -1, 4'hE, 7'h0E, 1'b0));
        vecs.push_back(mkVec(16'h12AF, 4'b0001, 4'b0000, 4'b0000, 1, -1, 4'hD, 7'h08, 1'b1));
        vecs.push_back(mkVec(16'h12AF, 4'b0001, 4'b0000, 4'b0000, 2, -1, 4'hB, 7'h24, 1'b1));
        vecs.push_back(mkVec(16'h12AF, 4'b0001, 4'b0000, 4'b0000, 3, -1, 4'h7, 7'h79, 1'b1));
        vecs.push_back(mkVec(16'hC789, 4'b1010, 4'b0000, 4'b0000, 0, -1, 4'hE, 7'h10, 1'b1));
        vecs.push_back(mkVec(16'hC789, 4'b1010, 4'b0000, 4'b0000, 1, -1, 4'hD, 7'h00, 1'b0));
        vecs.push_back(mkVec(16'hC789, 4'b1010, 4'b0000, 4'b0000, 2, -1, 4'hB, 7'h78, 1'b1));
        vecs.push_back(mkVec(16'hC789, 4'b1010, 4'b0000, 4'b0000, 3, -1, 4'h7, 7'h46, 1'b0));
        vecs.push_back(mkVec(16'hBDE6, 4'b0000, 4'b0000, 4'b0000, 0, -1, 4'hE, 7'h02, 1'b1));
        vecs.push_back(mkVec(16'hBDE6, 4'b0000, 4'b0000, 4'b0000, 1, -1, 4'hD, 7'h06, 1'b1));
        vecs.push_back(mkVec(16'hBDE6, 4'b0000, 4'b0000, 4'b0000, 2, -1, 4'hB, 7'h21, 1'b1));
        vecs.push_back(mkVec(16'hBDE6, 4'b0000, 4'b0000, 4'b0000, 3, -1, 4'h7, 7'h03, 1'b1));
        vecs.push_back(mkVec(16'h4053, 4'b0000, 4'b0100, 4'b0000, 0, -1, 4'hE, 7'h30, 1'b1));
        vecs.push_back(mkVec(16'h4053, 4'b0000, 4'b0100, 4'b0000, 1, -1, 4'hD, 7'h12, 1'b1));
        vecs.push_back(mkVec(16'h4053, 4'b0100, 4'b0100, 4'b0000, 2, -1, 4'hF, 7'h7F, 1'b1));
        vecs.push_back(mkVec(16'h4053, 4'b0000, 4'b0100, 4'b0000, 3, -1, 4'h7, 7'h19, 1'b1));
        vecs.push_back(mkVec(16'h1234, 4'b0000, 4'b0000, 4'b0001, 0,  0, 4'hE, 7'h19, 1'b1));
        vecs.push_back(mkVec(16'h1234, 4'b0001, 4'b0000, 4'b0001, 0,  1, 4'hF, 7'h7F, 1'b1));
        vecs.push_back(mkVec(16'h1234, 4'b0000, 4'b0000, 4'b0001, 1,  1, 4'hD, 7'h30, 1'b1));
        vecs.push_back(mkVec(16'h1234, 4'b0000, 4'b0000, 4'b0001, 3,  1, 4'h7, 7'h79, 1'b1));
`ifdef SSEG_LZB_EN
        vecs.push_back(mkVec(16'h0030, 4'b1111, 4'b0000, 4'b0000, 3, -1, 4'hF, 7'h7F, 1'b1));
        vecs.push_back(mkVec(16'h0030, 4'b1111, 4'b0000, 4'b0000, 2, -1, 4'hF, 7'h7F, 1'b1));
        vecs.push_back(mkVec(16'h0000, 4'b0000, 4'b0000, 4'b0000, 1, -1, 4'hF, 7'h7F, 1'b1));
`else
        vecs.push_back(mkVec(16'h0030, 4'b1111, 4'b0000, 4'b0000, 3, -1, 4'h7, 7'h40, 1'b0));
        vecs.push_back(mkVec(16'h0030, 4'b1111, 4'b0000, 4'b0000, 2, -1, 4'hB, 7'h40, 1'b0));
        vecs.push_back(mkVec(16'h0000, 4'b0000, 4'b0000, 4'b0000, 1, -1, 4'hD, 7'h40, 1'b1));
`endif
        vecs.push_back(mkVec(16'h0030, 4'b1111, 4'b0000, 4'b0000, 1, -1, 4'hD, 7'h30, 1'b0));
        vecs.push_back(mkVec(16'h0030, 4'b1111, 4'b0000, 4'b0000, 0, -1, 4'hE, 7'h40, 1'b0));
        vecs.push_back(mkVec(16'h0000, 4'b0000, 4'b0000, 4'b0000, 0, -1, 4'hE, 7'h40, 1'b1));

        // Reset held with load asserted: outputs dark, nothing captured.
        rst_n = 1'b0; load = 1'b1; digits = 16'hFFFF;
        dp_in = 4'hF; blank_in = 4'h0; blink_in = 4'h0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checkOutput($sformatf("reset cycle %0d", i), 4'hF, 7'h7F, 1'b1);
            checkTick($sformatf("reset tick %0d", i), 1'b0);
        end
        rst_n = 1'b1; load = 1'b0; digits = 16'h0000; dp_in = 4'h0;
        @(negedge clk);
        checkOutput("first slot guard", 4'hF, 7'h7F, 1'b1);
        waitPos("post-reset slot0", 0, 4, -1);
        checkOutput("shadow zero slot0", 4'hE, 7'h40, 1'b1);
        waitPos("post-reset slot3", 3, 4, -1);
`ifdef SSEG_LZB_EN
        checkOutput("shadow zero slot3", 4'hF, 7'h7F, 1'b1);
`else
        checkOutput("shadow zero slot3", 4'h7, 7'h40, 1'b1);
`endif

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].digits, vecs[i].dpIn, vecs[i].blankIn, vecs[i].blinkIn);
            waitPos($sformatf("vec %0d", i), vecs[i].slot, 4, vecs[i].phase);
            checkOutput($sformatf("vec %0d slot %0d", i, vecs[i].slot),
                        vecs[i].expAn, vecs[i].expSeg, vecs[i].expDp);
        end

        // Full scan walk: guard cycles, visible cycles and tick spacing.
        applyStimulus(16'h12AF, 4'b0001, 4'b0000, 4'b0000);
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            c = curCnt();
            ix = curIdx();
            if (c < 2)
                checkOutput($sformatf("walk guard i=%0d", i), 4'hF, 7'h7F, 1'b1);
            else
                checkOutput($sformatf("walk slot%0d cnt%0d", ix, c), walkAn[ix], walkSeg[ix], walkDp[ix]);
            checkTick($sformatf("walk tick cnt%0d", c), c == 7);
        end

        // Blink on digit0 across visible and dark phases.
        applyStimulus(16'h1234, 4'b0000, 4'b0000, 4'b0001);
        for (int i = 0; i < 192; i++) begin
            @(negedge clk);
            if (curIdx() == 0 && curCnt() >= 2)
                checkOutput($sformatf("blink phase%0d cnt%0d", curPhase(), curCnt()),
                            curPhase() == 1 ? 4'hF : 4'hE,
                            curPhase() == 1 ? 7'h7F : 7'h19, 1'b1);
        end

        // Mid-slot load changes the active digit without restarting the scan.
        applyStimulus(16'h0001, 4'b0000, 4'b0000, 4'b0000);
        waitPos("midload position", 0, 3, -1);
        checkOutput("midload before", 4'hE, 7'h79, 1'b1);
        digits = 16'h0005; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        checkOutput("midload load edge", 4'hE, 7'h79, 1'b1);
        @(negedge clk);
        checkOutput("midload next edge", 4'hE, 7'h12, 1'b1);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            checkTick($sformatf("midload tick cnt%0d", curCnt()), curCnt() == 7);
        end

        // Reset mid-scan: dark next cycle, restart at slot 0 with full guard.
        applyStimulus(16'h12AF, 4'b0001, 4'b0000, 4'b0000);
        waitPos("midreset position", 1, 5, -1);
        checkOutput("midreset before", 4'hD, 7'h08, 1'b1);
        rst_n = 1'b0;
        @(negedge clk);
        checkOutput("midreset dark", 4'hF, 7'h7F, 1'b1);
        checkTick("midreset tick", 1'b0);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("restart guard0", 4'hF, 7'h7F, 1'b1);
        @(negedge clk);
        checkOutput("restart guard1", 4'hF, 7'h7F, 1'b1);
        @(negedge clk);
        checkOutput("restart slot0 visible", 4'hE, 7'h40, 1'b1);
        waitPos("restart tick position", 0, 7, -1);
        checkTick("restart first tick", 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule

// File: doc/sseg_scan_driver.md
Name: sseg_scan_driver

Overview:
- Drives the board's multiplexed 4-digit seven-segment display (seg, dp, an, all active-low) from a 16-bit hex value loaded by the top level.
- This is the producing end of the seg/an interface the top-level bench observes.
- Holds double-buffered display content, a refresh scan counter, an anti-ghosting guard interval, per-digit blanking and per-digit blink.
- Instanced once per display in top.

Parameters:
- REFRESH_DIV, 100000: clk cycles per digit slot (1 kHz slot rate at 100 MHz); must be >= 2.
- GUARD_CYC, 4: cycles at the start of each slot during which all anodes are off; must be < REFRESH_DIV.
- BLINK_DIV, 50000000: clk cycles per blink phase; must be >= 2.

Ports:
- clk  in  1  system clock, 100 MHz
- rst_n  in  1  synchronous active-low reset
- load  in  1  capture digits/dp_in/blank_in/blink_in into shadow registers at this edge
- digits  in  16  four hex nibbles; [3:0] = digit0 (rightmost, an[0]) ... [15:12] = digit3
- dp_in  in  4  decimal point per digit, 1 = lit
- blank_in  in  4  per-digit force-blank, 1 = dark
- blink_in  in  4  per-digit blink enable
- seg  out  7  cathodes, active-low; seg[0]=a ... seg[6]=g
- dp  out  1  decimal-point cathode, active-low
- an  out  4  anodes, active-low, at most one low at any time
- scan_tick  out  1  one-cycle pulse when the slot index advances

Behaviour:
- Reset (rst_n=0 at an edge) has priority over load.
- Reset values:
  - an=4'b1111, seg=7'h7F, dp=1, scan_tick=0.
  - Slot counter cnt=0, index idx=0, blink counter=0, blink_phase=0 (visible).
  - Shadow registers: digits=0, dp=0, blank=0, blink=0.
- Reset mid-scan: outputs dark on the following cycle; scanning restarts at slot 0 with a full guard interval.
- cnt counts 0..REFRESH_DIV-1.
  - At REFRESH_DIV-1, cnt wraps to 0 and idx increments mod 4 (3 wraps to 0).
  - scan_tick is registered: high exactly the cycle after the wrap edge, once every REFRESH_DIV cycles.
- Output registers are updated every edge from the pre-edge values of cnt, idx and the shadow registers, giving one cycle of latency.
  - Dark (an=1111, seg=7F, dp=1) if cnt < GUARD_CYC, OR shadow blank[idx]=1, OR (blink[idx]=1 AND blink_phase=1).
  - Otherwise: an = ~(4'b0001 << idx), seg = decode(nibble idx), dp = ~dp_shadow[idx].
  - Each anode is therefore low for exactly REFRESH_DIV-GUARD_CYC consecutive cycles per visible slot.
- Decode table (active-low, order g..a):
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E (hex).
- Load:
  - Shadow registers update at the load edge.
  - The new content appears on outputs at the next edge, including mid-slot for the currently active digit; the scan is not restarted.
  - load held high simply recaptures every cycle.
- Blink:
  - The blink counter counts 0..BLINK_DIV-1 and toggles blink_phase on wrap.
  - It runs independently of the slot counter and is not reset by load.

Optional Feature:
- Macro: SSEG_LZB_EN (leading-zero blanking).
- With SSEG_LZB_EN defined:
  - Digit k (k=3..1) is also dark when its nibble and every higher nibble are 0.
  - Digit0 is never LZB-blanked.
  - LZB is evaluated on shadow values.
  - dp_in on an LZB-blanked digit is suppressed.
- Without it: zeros are displayed as "0" on all digits; behaviour otherwise identical.

Test Plan (REFRESH_DIV=8, GUARD_CYC=2, BLINK_DIV=64 unless noted):
- rst_n=0 for 10 cycles with load=1, digits=FFFF -> an=1111, seg=7F, dp=1, scan_tick=0 throughout; shadow remains 0 after release.
- Release reset, load digits=16'h12AF, dp_in=4'b0001 -> scan visits an=1110 seg=0E dp=0, then 1101/08, 1011/24, 0111/79, then repeats. Each anode is low 6 consecutive cycles followed by 2 dark cycles; scan_tick pulses every 8 cycles.
- blank_in=4'b0100 loaded -> an[2] never low; during slot 2 an=1111, seg=7F for all 8 cycles; other slots unchanged.
- blink_in=4'b0001 loaded -> an[0] is low in its slots during 64-cycle visible phases and never low during the alternating 64-cycle dark phases.
- Load digits=16'h0005 while slot 0 is showing 1 (seg=79) -> seg=12 one edge after the load edge, same slot, with no change to idx or scan_tick spacing.
- SSEG_LZB_EN defined, digits=16'h0030 -> digits 3 and 2 dark, digit1 seg=30, digit0 seg=40. digits=16'h0000 -> only an[0] ever low, showing seg=40.
